// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, issues request-to-send,
// then shifts one odd-parity byte out on device clock falls and checks the ACK.
module ps2_host_tx #(
  parameter int CLK_HZ     = 14000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INHIBIT_CYC = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int CNT_MAX     = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_XFER,
    S_WAITIDLE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [9:0]       shift_q, shift_d;
  logic             ack_q, ack_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             timeout_q, timeout_d;
  logic             ready_q, ready_d;
  logic             inhibit_q, inhibit_d;

  logic clk_meta_q, clk_s_q, clk_prev_q;
  logic data_meta_q, data_s_q;
  logic fall;

  // Synchronisers idle high so leaving reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_s_q     <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_s_q    <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_s_q     <= clk_meta_q;
      clk_prev_q  <= clk_s_q;
      data_meta_q <= ps2_data_in;
      data_s_q    <= data_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      ack_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      ready_q   <= 1'b1;
      inhibit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      ack_q     <= ack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
      ready_q   <= ready_d;
      inhibit_q <= inhibit_d;
    end
  end

  // Next-state and registered-output logic; the shift register holds
  // {stop, parity, data} and presents the next bit to drive at bit 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    ack_d     = ack_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    ack_err_d = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_start) begin
          shift_d  = {1'b1, ~^tx_data, tx_data};
          cnt_d    = '0;
          bit_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RTS: begin
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_XFER;
      end
      S_XFER: begin
        if (fall) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd10) begin
            ack_d     = data_s_q;
            data_oe_d = 1'b0;
            state_d   = S_WAITIDLE;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[9:1]};
          end
        end else if (cnt_q == TO_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAITIDLE: begin
        if (clk_s_q && data_s_q) begin
          done_d    = 1'b1;
          ack_err_d = ack_q;
          state_d   = S_IDLE;
        end else if (fall) begin
          cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    ready_d   = (state_d == S_IDLE);
    inhibit_d = (state_d != S_IDLE);
  end

  assign tx_ready    = ready_q;
  assign tx_done     = done_q;
  assign tx_ack_err  = ack_err_q;
  assign tx_timeout  = timeout_q;
  assign rx_inhibit  = inhibit_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device model clocks
// frames out of the host and the received bits are compared to a frame model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int CLK_HZ     = 14000000;
  localparam int INHIBIT_US = 100;
  localparam int TIMEOUT_US = 1000;
  localparam int INH_CYC    = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int TO_CYC     = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int HALF_SLOW  = 560;
  localparam int HALF_FAST  = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_ready, tx_done, tx_ack_err, tx_timeout, rx_inhibit;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int checks = 0;
  int passes = 0;
  int done_pulses = 0;
  int to_pulses = 0;

  always #36 clk = ~clk;

  // Open-drain wired-AND of host and device on both lines.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_ack_err(tx_ack_err),
    .tx_timeout(tx_timeout), .rx_inhibit(rx_inhibit),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_pulses++;
    if (tx_timeout === 1'b1) to_pulses++;
  end

  // Expected line levels seen by the device, in transmission order.
  function automatic logic [10:0] frame_model(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      if (d[i]) ones++;
    end
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic measure_inhibit(input bit poke, output int hi, output int first);
    hi = 0;
    first = 0;
    while (ps2_clk_oe === 1'b1 && hi < 5000) begin
      hi++;
      if (ps2_data_oe === 1'b1 && first == 0) first = hi;
      if (poke && hi == 700) begin
        tx_start = 1'b1;
        tx_data  = 8'h12;
      end else begin
        tx_start = 1'b0;
      end
      @(negedge clk);
    end
    tx_start = 1'b0;
  endtask

  task automatic device(input int half, input bit ack, input int nfalls,
                        output logic [10:0] bits, output bit ok);
    int w;
    ok = 1'b1;
    bits = '0;
    w = 0;
    while (ps2_clk_oe !== 1'b0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) begin
      ok = 1'b0;
      return;
    end
    repeat (half) @(negedge clk);
    bits[0] = ps2_data_in;
    for (int n = 1; n <= nfalls; n++) begin
      if (n == 11 && ack) begin
        dev_data = 1'b0;
        repeat (half / 2) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (half) @(negedge clk);
      if (n == nfalls && nfalls < 11) return;
      dev_clk = 1'b1;
      if (n <= 10) begin
        bits[n] = ps2_data_in;
        repeat (half) @(negedge clk);
      end else begin
        dev_data = 1'b1;
      end
    end
  endtask

  task automatic wait_done(output bit seen, output logic ack, output logic after);
    seen = 1'b0;
    ack = 1'bx;
    for (int w = 0; w < 300; w++) begin
      if (tx_done === 1'b1) begin
        seen = 1'b1;
        ack = tx_ack_err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    after = tx_done;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_ready, tx_done, tx_ack_err, tx_timeout, rx_inhibit, ps2_clk_oe, ps2_data_oe} !== 7'b1000000)
      $display("[TB] FAIL reset_state: got %b want 1000000",
               {tx_ready, tx_done, tx_ack_err, tx_timeout, rx_inhibit, ps2_clk_oe, ps2_data_oe});
    else passes++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_glitch;
    int bad, d0, t0;
    bad = 0;
    d0 = done_pulses;
    t0 = to_pulses;
    dev_clk = 1'b0;
    for (int i = 0; i < 90; i++) begin
      if (i == 70) dev_clk = 1'b1;
      @(negedge clk);
      if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1 || rx_inhibit !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) $display("[TB] FAIL idle_glitch: got %0d disturbed cycles want 0", bad);
    else passes++;
    checks++;
    if ((done_pulses - d0) + (to_pulses - t0) !== 0)
      $display("[TB] FAIL idle_glitch_pulses: got %0d want 0", (done_pulses - d0) + (to_pulses - t0));
    else passes++;
  endtask

  task automatic test_ack_frame;
    int hi, first, d0;
    logic [10:0] bits;
    bit ok, seen;
    logic ack, after;
    d0 = done_pulses;
    start_tx(8'hED);
    checks++;
    if ({tx_ready, rx_inhibit} !== 2'b01)
      $display("[TB] FAIL start_flags: got %b want 01", {tx_ready, rx_inhibit});
    else passes++;
    measure_inhibit(1'b1, hi, first);
    checks++;
    if (hi !== INH_CYC + 1) $display("[TB] FAIL inhibit_len: got %0d want %0d", hi, INH_CYC + 1);
    else passes++;
    checks++;
    if (first !== INH_CYC + 1) $display("[TB] FAIL rts_cycle: got %0d want %0d", first, INH_CYC + 1);
    else passes++;
    fork
      device(HALF_SLOW, 1'b1, 11, bits, ok);
      begin
        repeat (4000) @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        repeat (3) @(negedge clk);
        tx_start = 1'b0;
      end
    join
    checks++;
    if (!ok || bits !== frame_model(8'hED))
      $display("[TB] FAIL ed_bits: got %b want %b", bits, frame_model(8'hED));
    else passes++;
    wait_done(seen, ack, after);
    checks++;
    if ({seen, ack, after} !== 3'b100)
      $display("[TB] FAIL ed_done: got seen/ack/after %b want 100", {seen, ack, after});
    else passes++;
    repeat (20) @(negedge clk);
    checks++;
    if ({ps2_clk_oe, tx_ready, done_pulses - d0} !== {1'b0, 1'b1, 32'd1})
      $display("[TB] FAIL ed_no_requeue: got oe=%b rdy=%b done=%0d want 0 1 1",
               ps2_clk_oe, tx_ready, done_pulses - d0);
    else passes++;
  endtask

  task automatic test_nack;
    int hi, first;
    logic [10:0] bits;
    bit ok, seen;
    logic ack, after;
    start_tx(8'hF4);
    measure_inhibit(1'b0, hi, first);
    device(HALF_FAST, 1'b0, 11, bits, ok);
    checks++;
    if (!ok || bits !== frame_model(8'hF4))
      $display("[TB] FAIL f4_bits: got %b want %b", bits, frame_model(8'hF4));
    else passes++;
    checks++;
    if (bits[9] !== 1'b0) $display("[TB] FAIL f4_parity: got %b want 0", bits[9]);
    else passes++;
    wait_done(seen, ack, after);
    checks++;
    if ({seen, ack, after} !== 3'b110)
      $display("[TB] FAIL f4_nack: got seen/ack/after %b want 110", {seen, ack, after});
    else passes++;
  endtask

  task automatic test_timeout;
    int hi, first, k, d0, t0;
    d0 = done_pulses;
    t0 = to_pulses;
    start_tx(8'hFF);
    measure_inhibit(1'b0, hi, first);
    k = 0;
    while (tx_timeout !== 1'b1 && k < TO_CYC + 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== TO_CYC) $display("[TB] FAIL timeout_cycles: got %0d want %0d", k, TO_CYC);
    else passes++;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00)
      $display("[TB] FAIL timeout_release: got %b want 00", {ps2_clk_oe, ps2_data_oe});
    else passes++;
    @(negedge clk);
    checks++;
    if ({tx_ready, tx_timeout, rx_inhibit} !== 3'b100)
      $display("[TB] FAIL timeout_after: got %b want 100", {tx_ready, tx_timeout, rx_inhibit});
    else passes++;
    checks++;
    if ({done_pulses - d0, to_pulses - t0} !== {32'd0, 32'd1})
      $display("[TB] FAIL timeout_pulses: got done=%0d to=%0d want 0 1", done_pulses - d0, to_pulses - t0);
    else passes++;
  endtask

  task automatic test_reset_mid;
    int hi, first, d0, t0;
    logic [10:0] bits;
    bit ok, seen;
    logic ack, after;
    d0 = done_pulses;
    t0 = to_pulses;
    start_tx(8'h00);
    measure_inhibit(1'b0, hi, first);
    device(HALF_FAST, 1'b1, 5, bits, ok);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001)
      $display("[TB] FAIL reset_mid: got oe/oe/rdy %b want 001", {ps2_clk_oe, ps2_data_oe, tx_ready});
    else passes++;
    reset = 1'b0;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    repeat (50) @(negedge clk);
    checks++;
    if ({done_pulses - d0, to_pulses - t0} !== {32'd0, 32'd0})
      $display("[TB] FAIL reset_mid_pulses: got done=%0d to=%0d want 0 0", done_pulses - d0, to_pulses - t0);
    else passes++;
    start_tx(8'h01);
    measure_inhibit(1'b0, hi, first);
    device(HALF_FAST, 1'b1, 11, bits, ok);
    checks++;
    if (!ok || bits !== frame_model(8'h01) || bits[9] !== 1'b0)
      $display("[TB] FAIL post_reset_bits: got %b want %b", bits, frame_model(8'h01));
    else passes++;
    wait_done(seen, ack, after);
    checks++;
    if ({seen, ack, after} !== 3'b100)
      $display("[TB] FAIL post_reset_done: got %b want 100", {seen, ack, after});
    else passes++;
  endtask

  task automatic test_back_to_back;
    int hi, first;
    logic [10:0] bits;
    logic [7:0] d;
    bit ok, seen, devack;
    logic ack, after;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      devack = 1'($urandom_range(0, 1));
      start_tx(d);
      measure_inhibit(1'b0, hi, first);
      device(HALF_FAST, devack, 11, bits, ok);
      checks++;
      if (!ok || bits !== frame_model(d))
        $display("[TB] FAIL rand_bits[%0d]: got %b want %b (data %h)", i, bits, frame_model(d), d);
      else passes++;
      wait_done(seen, ack, after);
      checks++;
      if ({seen, ack, after} !== {1'b1, ~devack, 1'b0})
        $display("[TB] FAIL rand_done[%0d]: got %b want %b", i, {seen, ack, after}, {1'b1, ~devack, 1'b0});
      else passes++;
    end
  endtask

  initial begin
    test_reset;
    test_glitch;
    test_ack_frame;
    test_nack;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: serialises one command byte (LED set 0xED, reset 0xFF, typematic, echo) from the system side to the keyboard on the shared open-drain PS/2 lines. Sits beside `zxkbd` on the `clock_kb` (14 MHz) domain. Drives the lines only through open-drain enables and raises `rx_inhibit` so the receiver ignores host-generated line activity. Transmit only; the keyboard's reply (0xFA etc.) is decoded by `zxkbd`.

## Interface
- `CLK_HZ`, 14000000, frequency of `clk` in Hz
- `INHIBIT_US`, 100, clock-inhibit time before request-to-send, in µs
- `TIMEOUT_US`, 15000, maximum gap allowed between device clock events, in µs
- Derived cycle counts: INHIBIT_CYC = CLK_HZ/1000000*INHIBIT_US (1400); TIMEOUT_CYC = CLK_HZ/1000000*TIMEOUT_US (210000). The counter is 18 bits, sized by $clog2.
- `clk`  in  1  system clock; all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `tx_data`  in  8  byte to send; sampled when `tx_start && tx_ready`
- `tx_start`  in  1  request; honoured only while `tx_ready`=1
- `tx_ready`  out  1  idle, can accept a byte
- `tx_done`  out  1  one-cycle pulse, frame finished, lines idle
- `tx_ack_err`  out  1  valid with `tx_done`; 1 = device did not ACK (data high on 11th fall)
- `tx_timeout`  out  1  one-cycle pulse, frame aborted by timeout
- `rx_inhibit`  out  1  high whenever not IDLE
- `ps2_clk_in`  in  1  raw PS/2 clock pin level (asynchronous)
- `ps2_data_in`  in  1  raw PS/2 data pin level (asynchronous)
- `ps2_clk_oe`  out  1  1 = pull PS/2 clock low
- `ps2_data_oe`  out  1  1 = pull PS/2 data low

## Operation
- Both pin inputs pass through 2-flop synchronisers giving `clk_s` and `data_s`. A falling edge is detected when the previous `clk_s` was 1 and the current one is 0 (registered).
- Frame is 11 bits, sent LSB first: start 0, D0..D7, odd parity (parity = ~^tx_data), stop 1. The line is released for 1s and pulled for 0s.
- IDLE: `tx_ready`=1, both oe=0. When `tx_start` is seen, latch the shift register {stop, parity, data} and go to INHIBIT.
- INHIBIT: `ps2_clk_oe`=1 for INHIBIT_CYC cycles, then go to RTS.
- RTS: lasts 1 cycle with `ps2_clk_oe`=1 and `ps2_data_oe`=1 (start bit), then go to XFER. On entry to XFER `ps2_clk_oe`=0 and the timeout counter clears.
- XFER: keep a bit counter 0..10. Each falling edge increments it.
  - Falls 1..8: `ps2_data_oe` = ~D[n-1].
  - Fall 9: drive parity.
  - Fall 10: `ps2_data_oe`=0 (stop).
  - Fall 11: sample `data_s`, store `ack_err = data_s`, go to WAITIDLE.
- WAITIDLE: wait for `clk_s`=1 and `data_s`=1, then pulse `tx_done` with `tx_ack_err` and return to IDLE.
- Timeout: in XFER and WAITIDLE, the counter increments each cycle and clears on each falling edge. When it reaches TIMEOUT_CYC: both oe=0, pulse `tx_timeout`, go to IDLE. `tx_done` is not pulsed in this case.
- `tx_start` while not IDLE is ignored and no byte is queued. `tx_data` changes after acceptance have no effect.
- Falling edges seen in IDLE, INHIBIT or RTS are ignored.

## Timing
- Reset values: `tx_ready`=1; `tx_done`, `tx_ack_err`, `tx_timeout`, `rx_inhibit`, `ps2_clk_oe`, `ps2_data_oe` all 0; state IDLE; counters 0.
- Reset mid-frame releases both lines on the next posedge. No done or timeout pulse is produced.
- `tx_start` high at edge N gives `ps2_clk_oe`=1, `rx_inhibit`=1 and `tx_ready`=0 from edge N+1.
- `ps2_clk_oe` stays high for INHIBIT_CYC+1 cycles. `ps2_data_oe` rises at the last of those cycles.
- Pin fall to `ps2_data_oe` update: 3 cycles (2 sync + 1 edge register), about 214 ns, well inside the ≥30 µs low phase.
- `tx_done` or `tx_timeout` at edge M gives `tx_ready`=1 and `rx_inhibit`=0 at M+1. `tx_start` is accepted again at M+1.
- All outputs are registered.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz that samples on rising edges and ACKs (data low on fall 11). The model must receive 0,1,0,1,1,0,1,1,1,parity 1,stop 1. Required: `tx_done`=1 for 1 cycle, `tx_ack_err`=0.
- Send 0xF4 with a device that does not ACK. Required: parity bit 0, `tx_done` pulses with `tx_ack_err`=1.
- Send 0xFF with a device that never clocks after the clock is released. Required: `tx_timeout` pulses exactly TIMEOUT_CYC cycles after release, both oe=0, `tx_ready`=1 next cycle.
- Check inhibit timing. Required: `ps2_clk_oe` high for exactly 1401 cycles at 14 MHz, `ps2_data_oe` rising on cycle 1401. Pulse `tx_start` during the frame; it must have no effect.
- Assert `reset` after fall 5 of a 0x00 frame. Required: both oe=0 the next cycle, `tx_ready`=1, no done or timeout pulse. A subsequent 0x01 frame must complete with parity 0.
- Add a 5 µs glitch on `ps2_clk_in` during IDLE. Required: no state change, oe outputs stay 0.
